// File: rtl/ooo_resp_pkg.sv
// rtl/ooo_resp_pkg.sv - shared widths and entry record for the out-of-order read responder
package ooo_resp_pkg;

  localparam int ID_W    = 4;
  localparam int LAT_W   = 4;
  localparam int DEPTH_N = 4;
  localparam int IDX_W   = $clog2(DEPTH_N);
  localparam int DEP_W   = IDX_W + 1;
  localparam int SEQ_W   = 4;

  // dep counts older same-id entries still in the table; zero means this one may go next
  typedef struct packed {
    logic             valid;
    logic             issued;
    logic [ID_W-1:0]  id;
    logic [SEQ_W-1:0] seq;
    logic [LAT_W-1:0] cnt;
    logic [DEP_W-1:0] dep;
  } entry_t;

endpackage

// File: rtl/ooo_resp_pick.sv
// rtl/ooo_resp_pick.sv - combinational lowest-index picker over a request vector
module ooo_resp_pick
  import ooo_resp_pkg::*;
#(
  parameter int DEPTH = DEPTH_N
) (
  input  logic [DEPTH-1:0] eligible,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan high to low so the last hit written is the lowest index
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ooo_read_responder.sv
// rtl/ooo_read_responder.sv - AR/R slave returning one tagged beat per request after a programmable latency
module ooo_read_responder
  import ooo_resp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = ID_W,
  parameter int DEPTH      = DEPTH_N,
  parameter int LAT_WIDTH  = LAT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_arid_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  input  logic [LAT_WIDTH-1:0]  cfg_lat_i,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [ID_WIDTH-1:0]   s_rid_o,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i
);

  entry_t                tbl [DEPTH];
  logic [SEQ_W-1:0]      seq_ctr;
  logic [IDX_W-1:0]      r_idx;

  logic [DEPTH-1:0]      valid_vec;
  logic [DEPTH-1:0]      free_vec;
  logic [DEPTH-1:0]      elig_vec;
  logic                  free_found;
  logic [IDX_W-1:0]      free_idx;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;
  logic                  ar_fire;
  logic                  r_fire;
  logic                  r_load;
  logic [DEP_W-1:0]      same_id_cnt;
  logic [DATA_WIDTH-1:0] rdata_next;

  always_comb begin
    valid_vec = '0;
    elig_vec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = tbl[i].valid;
      elig_vec[i]  = tbl[i].valid && !tbl[i].issued &&
                     (tbl[i].cnt == '0) && (tbl[i].dep == '0);
    end
  end

  assign free_vec = ~valid_vec;

  ooo_resp_pick #(.DEPTH(DEPTH)) u_free_pick (
    .eligible (free_vec),
    .found    (free_found),
    .idx      (free_idx)
  );

  ooo_resp_pick #(.DEPTH(DEPTH)) u_r_pick (
    .eligible (elig_vec),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // Ready depends only on the registered table, so a slot freed this edge is usable next cycle
  assign s_arready_o = free_found;
  assign ar_fire     = s_arvalid_i && s_arready_o;
  assign r_fire      = s_rvalid_o && s_rready_i;
  assign r_load      = pick_found && (!s_rvalid_o || r_fire);

  // Older same-id requests still outstanding, not counting the one leaving on this edge
  always_comb begin
    same_id_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tbl[i].valid && (tbl[i].id == s_arid_i) &&
          !(r_fire && (r_idx == IDX_W'(i)))) begin
        same_id_cnt = same_id_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    rdata_next = '0;
    rdata_next[SEQ_W+ID_WIDTH-1:0] = {tbl[pick_idx].seq, tbl[pick_idx].id};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
      seq_ctr    <= '0;
      r_idx      <= '0;
      s_rvalid_o <= 1'b0;
      s_rid_o    <= '0;
      s_rdata_o  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_fire && (r_idx == IDX_W'(i))) begin
          tbl[i] <= '0;
        end else if (ar_fire && (free_idx == IDX_W'(i))) begin
          tbl[i].valid  <= 1'b1;
          tbl[i].issued <= 1'b0;
          tbl[i].id     <= s_arid_i;
          tbl[i].seq    <= seq_ctr;
          tbl[i].cnt    <= cfg_lat_i;
          tbl[i].dep    <= same_id_cnt;
        end else begin
          if (tbl[i].cnt != '0) begin
            tbl[i].cnt <= tbl[i].cnt - 1'b1;
          end
          if (r_fire && tbl[i].valid && (tbl[i].id == s_rid_o) && (tbl[i].dep != '0)) begin
            tbl[i].dep <= tbl[i].dep - 1'b1;
          end
          if (r_load && (pick_idx == IDX_W'(i))) begin
            tbl[i].issued <= 1'b1;
          end
        end
      end

      if (ar_fire) begin
        seq_ctr <= seq_ctr + 1'b1;
      end

      if (r_load) begin
        s_rvalid_o <= 1'b1;
        s_rid_o    <= tbl[pick_idx].id;
        s_rdata_o  <= rdata_next;
        r_idx      <= pick_idx;
      end else if (r_fire) begin
        s_rvalid_o <= 1'b0;
      end
    end
  end

endmodule
